// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: arbitrates ALU/load results onto the register-file write port
// and tracks per-register pending writes. Optional forwarding outputs: REGFILE_WB_BYPASS_EN.
module regfile_wb_sched #(
  parameter int N          = 32,
  parameter int W          = 32,
  parameter int CNT_W      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 iss_valid,
  input  logic [$clog2(N)-1:0] iss_rd,
  output logic                 iss_stall,
  output logic [N-1:0]         busy,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [$clog2(N)-1:0] alu_rd,
  input  logic [W-1:0]         alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [$clog2(N)-1:0] mem_rd,
  input  logic [W-1:0]         mem_data,
  output logic                 wen,
  output logic [$clog2(N)-1:0] waddr,
  output logic [W-1:0]         wdata,
  output logic                 err
`ifdef REGFILE_WB_BYPASS_EN
  ,
  output logic                 fwd_valid,
  output logic [$clog2(N)-1:0] fwd_rd,
  output logic [W-1:0]         fwd_data
`endif
);

  localparam int AW = $clog2(N);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [AW-1:0]    RD_ZERO    = {AW{1'b0}};

  logic                alu_forced_s;
  logic                grant_s;
  logic [AW-1:0]       grant_rd_s;
  logic [W-1:0]        grant_data_s;
  logic [SW-1:0]       starve_r;
  logic [CNT_W-1:0]    cnt_r [N];
  logic [N-1:0]        inc_s;
  logic [N-1:0]        dec_s;
  logic [N-1:0]        busy_s;
  logic                underflow_s;
  logic                wen_r;
  logic [AW-1:0]       waddr_r;
  logic [W-1:0]        wdata_r;
  logic                err_r;

  // Arbitration: mem normally wins, a starved ALU is forced through.
  always_comb begin
    alu_forced_s = alu_valid && (starve_r == STARVE_LIM);
    mem_ready    = mem_valid && !alu_forced_s;
    alu_ready    = alu_valid && (!mem_valid || alu_forced_s);
    grant_s      = 1'b0;
    grant_rd_s   = RD_ZERO;
    grant_data_s = {W{1'b0}};
    if (mem_ready) begin
      grant_s      = 1'b1;
      grant_rd_s   = mem_rd;
      grant_data_s = mem_data;
    end else if (alu_ready) begin
      grant_s      = 1'b1;
      grant_rd_s   = alu_rd;
      grant_data_s = alu_data;
    end else begin
      grant_s      = 1'b0;
    end
  end

  assign iss_stall = iss_valid && (iss_rd != RD_ZERO) && (cnt_r[iss_rd] == CNT_MAX);

  // Per-register increment/decrement requests; register 0 never counts.
  always_comb begin
    inc_s          = {N{1'b0}};
    dec_s          = {N{1'b0}};
    inc_s[iss_rd]  = iss_valid && !iss_stall;
    dec_s[waddr_r] = wen_r;
    inc_s[0]       = 1'b0;
    dec_s[0]       = 1'b0;
    underflow_s    = wen_r && (waddr_r != RD_ZERO) && (cnt_r[waddr_r] == CNT_ZERO);
  end

  // Busy view; with forwarding, the final pending write is visible in its write cycle.
  always_comb begin
    busy_s = {N{1'b0}};
    for (int i = 1; i < N; i++) begin
`ifdef REGFILE_WB_BYPASS_EN
      busy_s[i] = (cnt_r[i] != CNT_ZERO) &&
                  !(wen_r && (waddr_r == AW'(i)) && (cnt_r[i] == CNT_ONE));
`else
      busy_s[i] = (cnt_r[i] != CNT_ZERO);
`endif
    end
  end

  assign busy  = busy_s;
  assign wen   = wen_r;
  assign waddr = waddr_r;
  assign wdata = wdata_r;
  assign err   = err_r;
`ifdef REGFILE_WB_BYPASS_EN
  assign fwd_valid = wen_r;
  assign fwd_rd    = waddr_r;
  assign fwd_data  = wdata_r;
`endif

  // Registered write port; a grant to register 0 is consumed without a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_r   <= 1'b0;
      waddr_r <= RD_ZERO;
      wdata_r <= {W{1'b0}};
    end else begin
      wen_r <= grant_s && (grant_rd_s != RD_ZERO);
      if (grant_s) begin
        waddr_r <= grant_rd_s;
        wdata_r <= grant_data_s;
      end else begin
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  // Starvation counter for the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_r <= {SW{1'b0}};
    end else if (alu_valid && !alu_ready) begin
      if (starve_r != STARVE_LIM) begin
        starve_r <= starve_r + SW'(1);
      end else begin
        starve_r <= starve_r;
      end
    end else begin
      starve_r <= {SW{1'b0}};
    end
  end

  // Pending-write counters; a decrement on an empty counter is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   cnt_r[i] <= cnt_r[i] + CNT_ONE;
          2'b01:   cnt_r[i] <= (cnt_r[i] == CNT_ZERO) ? CNT_ZERO : cnt_r[i] - CNT_ONE;
          2'b11:   cnt_r[i] <= (cnt_r[i] == CNT_ZERO) ? CNT_ONE : cnt_r[i];
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (underflow_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: vector table for issue/commit/arbitration,
// hand sequences for saturation, same-edge inc/dec, rd=0, underflow and async reset.
module tb_regfile_wb_sched;

  localparam int N = 32;
  localparam int W = 32;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iss_valid;
  logic [4:0]    iss_rd;
  logic          iss_stall;
  logic [N-1:0]  busy;
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [W-1:0]  alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_rd;
  logic [W-1:0]  mem_data;
  logic          wen;
  logic [4:0]    waddr;
  logic [W-1:0]  wdata;
  logic          err;
`ifdef REGFILE_WB_BYPASS_EN
  logic          fwd_valid;
  logic [4:0]    fwd_rd;
  logic [W-1:0]  fwd_data;
`endif

  regfile_wb_sched #(.N(N), .W(W), .CNT_W(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall), .busy(busy),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .err(err)
`ifdef REGFILE_WB_BYPASS_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [4:0] ir,
                        input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
    iss_valid = iv; iss_rd = ir;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    mem_valid = mv; mem_rd = mr; mem_data = md;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic        iv;  logic [4:0] ir;
    logic        av;  logic [4:0] ar; logic [31:0] ad;
    logic        mv;  logic [4:0] mr; logic [31:0] md;
    logic        ear; logic emr; logic est;
    logic        ewen; logic [4:0] ewaddr; logic [31:0] ewdata;
    logic [31:0] ebusy; logic eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, logic [4:0] ir, logic av, logic [4:0] ar, logic [31:0] ad,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic ear, logic emr, logic est,
                              logic ewen, logic [4:0] ewaddr, logic [31:0] ewdata,
                              logic [31:0] ebusy, logic eerr);
    vec_t v;
    v.iv = iv; v.ir = ir; v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md;
    v.ear = ear; v.emr = emr; v.est = est;
    v.ewen = ewen; v.ewaddr = ewaddr; v.ewdata = ewdata;
    v.ebusy = ebusy; v.eerr = eerr;
    return v;
  endfunction

  initial begin
    logic [31:0] b5;
    logic [31:0] b5_wr;
    logic [31:0] b46;
    b5    = 32'h0000_0020;
    b5_wr = BYP ? 32'h0 : 32'h0000_0020;
    b46   = BYP ? 32'h0000_0040 : 32'h0000_0050;

    // Issue rd5 then ALU commit; then 6-cycle mem/ALU contest (rd2 mem, rd1 alu).
    tbl.push_back(mk(1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0, 32'h0,1'b0));
    tbl.push_back(mk(1'b1,5'd5, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0, 32'h0,1'b0));
    tbl.push_back(mk(1'b0,5'd0, 1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0, b5,1'b0));
    tbl.push_back(mk(1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0, 1'b1,5'd5,32'hDEADBEEF, b5_wr,1'b0));
    tbl.push_back(mk(1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0, 32'h0,1'b0));
    tbl.push_back(mk(1'b0,5'd0, 1'b1,5'd1,32'hA1, 1'b1,5'd2,32'hB2, 1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0, 32'h0,1'b0));
    tbl.push_back(mk(1'b0,5'd0, 1'b1,5'd1,32'hA1, 1'b1,5'd2,32'hB2, 1'b0,1'b1,1'b0, 1'b1,5'd2,32'hB2, 32'h0,1'b0));
    tbl.push_back(mk(1'b0,5'd0, 1'b1,5'd1,32'hA1, 1'b1,5'd2,32'hB2, 1'b0,1'b1,1'b0, 1'b1,5'd2,32'hB2, 32'h0,1'b1));
    tbl.push_back(mk(1'b0,5'd0, 1'b1,5'd1,32'hA1, 1'b1,5'd2,32'hB2, 1'b0,1'b1,1'b0, 1'b1,5'd2,32'hB2, 32'h0,1'b1));
    tbl.push_back(mk(1'b0,5'd0, 1'b1,5'd1,32'hA1, 1'b1,5'd2,32'hB2, 1'b1,1'b0,1'b0, 1'b1,5'd2,32'hB2, 32'h0,1'b1));
    tbl.push_back(mk(1'b0,5'd0, 1'b1,5'd1,32'hA1, 1'b1,5'd2,32'hB2, 1'b0,1'b1,1'b0, 1'b1,5'd1,32'hA1, 32'h0,1'b1));
    tbl.push_back(mk(1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0, 1'b1,5'd2,32'hB2, 32'h0,1'b1));
    tbl.push_back(mk(1'b0,5'd0, 1'b0,5'd0,32'h0, 1'b0,5'd0,32'h0, 1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0, 32'h0,1'b1));

    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wen", wen, 1'b0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < tbl.size(); k++) begin
      set_in(tbl[k].iv, tbl[k].ir, tbl[k].av, tbl[k].ar, tbl[k].ad, tbl[k].mv, tbl[k].mr, tbl[k].md);
      #1;
      chk($sformatf("v%0d_alu_ready", k), alu_ready, tbl[k].ear);
      chk($sformatf("v%0d_mem_ready", k), mem_ready, tbl[k].emr);
      chk($sformatf("v%0d_iss_stall", k), iss_stall, tbl[k].est);
      chk($sformatf("v%0d_wen", k), wen, tbl[k].ewen);
      if (tbl[k].ewen) begin
        chk($sformatf("v%0d_waddr", k), waddr, tbl[k].ewaddr);
        chk($sformatf("v%0d_wdata", k), wdata, tbl[k].ewdata);
      end
      chk($sformatf("v%0d_busy", k), busy, tbl[k].ebusy);
      chk($sformatf("v%0d_err", k), err, tbl[k].eerr);
`ifdef REGFILE_WB_BYPASS_EN
      chk($sformatf("v%0d_fwd_valid", k), fwd_valid, tbl[k].ewen);
`endif
      @(negedge clk);
    end

    do_reset();
    #1;
    chk("rst2_err", err, 1'b0);

    // Counter saturation at 3, then one commit frees a slot.
    set_in(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("sat_issue%0d", k), iss_stall, 1'b0);
      @(negedge clk);
    end
    set_in(1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
    #1;
    chk("sat_stall", iss_stall, 1'b1);
    chk("sat_busy7", busy[7], 1'b1);
    chk("sat_alu_ready", alu_ready, 1'b1);
    @(negedge clk);
    set_in(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("sat_wen", wen, 1'b1);
    chk("sat_waddr", waddr, 5'd7);
    chk("sat_stall_nocredit", iss_stall, 1'b1);
    @(negedge clk);
    #1;
    chk("sat_reissue", iss_stall, 1'b0);
    @(negedge clk);

    // Issue and commit to the same register on the same edge.
    do_reset();
    set_in(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    set_in(1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    set_in(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("same_wen", wen, 1'b1);
    chk("same_waddr", waddr, 5'd3);
    chk("same_stall", iss_stall, 1'b0);
    chk("same_busy3_wr", busy[3], BYP ? 1'b0 : 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("same_busy3_after", busy[3], 1'b1);
    chk("same_wen_after", wen, 1'b0);
    @(negedge clk);
    #1;
    chk("same_busy3_hold", busy[3], 1'b1);

    // rd=0 accepted with no write.
    do_reset();
    set_in(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("rd0_mem_ready", mem_ready, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("rd0_wen", wen, 1'b0);
    chk("rd0_busy", busy, 32'h0);
    chk("rd0_err", err, 1'b0);
    @(negedge clk);

    // Underflow on rd9 makes err sticky.
    set_in(1'b0, 5'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    #1;
    chk("uf_alu_ready", alu_ready, 1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("uf_wen", wen, 1'b1);
    chk("uf_waddr", waddr, 5'd9);
    chk("uf_err_before", err, 1'b0);
    @(negedge clk);
    #1;
    chk("uf_err_set", err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("uf_err_sticky", err, 1'b1);

    // Asynchronous reset in the write cycle.
    set_in(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    set_in(1'b1, 5'd6, 1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    idle();
    #1;
    chk("ar_wen_pre", wen, 1'b1);
    chk("ar_waddr_pre", waddr, 5'd4);
    chk("ar_busy_pre", busy, b46);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wen", wen, 1'b0);
    chk("ar_waddr", waddr, 5'd0);
    chk("ar_wdata", wdata, 32'h0);
    chk("ar_busy", busy, 32'h0);
    chk("ar_err", err, 1'b0);
`ifdef REGFILE_WB_BYPASS_EN
    chk("ar_fwd_valid", fwd_valid, 1'b0);
`endif
    @(negedge clk);
    #1;
    chk("ar_wen_held", wen, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_wen_release", wen, 1'b0);
    chk("ar_busy_release", busy, 32'h0);
    chk("ar_err_release", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
